// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response handshakes and the shared ALU bus for alu_share_arbiter.
interface alu_share_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4,
  parameter int FLAG_W = 3
);
  logic              req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic [XLEN-1:0]   req0_a, req0_b, resp0_result;
  logic [CTRL_W-1:0] req0_ctrl;
  logic [FLAG_W-1:0] resp0_flags;
  logic              req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [XLEN-1:0]   req1_a, req1_b, resp1_result;
  logic [CTRL_W-1:0] req1_ctrl;
  logic [FLAG_W-1:0] resp1_flags;
  logic [XLEN-1:0]   alu_src_a, alu_src_b, alu_result;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [FLAG_W-1:0] alu_flags;
  logic              busy;
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl, resp0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctrl, resp1_ready,
    input  alu_result, alu_flags,
    output req0_ready, resp0_valid, resp0_result, resp0_flags,
    output req1_ready, resp1_valid, resp1_result, resp1_flags,
    output alu_src_a, alu_src_b, alu_ctrl, busy
  );
  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl, resp0_ready,
    output req1_valid, req1_a, req1_b, req1_ctrl, resp1_ready,
    output alu_result, alu_flags,
    input  req0_ready, resp0_valid, resp0_result, resp0_flags,
    input  req1_ready, resp1_valid, resp1_result, resp1_flags,
    input  alu_src_a, alu_src_b, alu_ctrl, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters with registered response slots.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module alu_share_arbiter #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4,
  parameter int FLAG_W = 3
) (
  input logic clk,
  input logic rst_n,
  alu_share_arbiter_if.slave bus
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0]        st0, st1;
  logic              elig0, elig1, grant0, grant1;
  logic [XLEN-1:0]   res0, res1;
  logic [FLAG_W-1:0] flg0, flg1;
  // A full slot may refill in the same cycle it drains.
  assign elig0 = bus.req0_valid && (st0 == EMPTY || bus.resp0_ready);
  assign elig1 = bus.req1_valid && (st1 == EMPTY || bus.resp1_ready);
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant0 = elig0;
  assign grant1 = elig1 && !elig0;
`else
  logic last_grant;
  assign grant0 = elig0 && (!elig1 || last_grant);
  assign grant1 = elig1 && (!elig0 || !last_grant);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= 1'b1;
    else if (grant0 || grant1) last_grant <= grant1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st0  <= EMPTY;
      st1  <= EMPTY;
      res0 <= '0;
      res1 <= '0;
      flg0 <= '0;
      flg1 <= '0;
    end else begin
      st0 <= grant0 ? FULL : (st0 == FULL && bus.resp0_ready) ? EMPTY : st0;
      st1 <= grant1 ? FULL : (st1 == FULL && bus.resp1_ready) ? EMPTY : st1;
      if (grant0) begin
        res0 <= bus.alu_result;
        flg0 <= bus.alu_flags;
      end
      if (grant1) begin
        res1 <= bus.alu_result;
        flg1 <= bus.alu_flags;
      end
    end
  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.resp0_valid  = st0 == FULL;
  assign bus.resp1_valid  = st1 == FULL;
  assign bus.resp0_result = res0;
  assign bus.resp1_result = res1;
  assign bus.resp0_flags  = flg0;
  assign bus.resp1_flags  = flg1;
  assign bus.busy         = (st0 == FULL) || (st1 == FULL);
  assign bus.alu_src_a    = grant0 ? bus.req0_a : grant1 ? bus.req1_a : '0;
  assign bus.alu_src_b    = grant0 ? bus.req0_b : grant1 ? bus.req1_b : '0;
  assign bus.alu_ctrl     = grant0 ? bus.req0_ctrl : grant1 ? bus.req1_ctrl : '0;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vector table plus backpressure and async-reset sequences.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  alu_share_arbiter_if bus ();
  alu_share_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // Reference ALU: 0001 subtracts, everything else adds; flags compare the operands.
  always_comb begin
    bus.alu_result = (bus.alu_ctrl == 4'b0001) ? bus.alu_src_a - bus.alu_src_b : bus.alu_src_a + bus.alu_src_b;
    bus.alu_flags  = {bus.alu_src_a == bus.alu_src_b, bus.alu_src_a < bus.alu_src_b, $signed(bus.alu_src_a) < $signed(bus.alu_src_b)};
  end
  typedef struct {
    logic v0; logic [31:0] a0, b0; logic [3:0] c0; logic rr0;
    logic v1; logic [31:0] a1, b1; logic [3:0] c1; logic rr1;
    logic g0, g1;
    logic rv0; logic [31:0] r0; logic [2:0] f0;
    logic rv1; logic [31:0] r1; logic [2:0] f1;
  } vec_t;
  vec_t vt [12];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
    else passed++;
  endtask
  task automatic drive(input logic v0, input logic [31:0] a0, b0, input logic [3:0] c0, input logic rr0,
                       input logic v1, input logic [31:0] a1, b1, input logic [3:0] c1, input logic rr1);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_ctrl = c0; bus.resp0_ready = rr0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_ctrl = c1; bus.resp1_ready = rr1;
  endtask
  initial begin
    vt[0]  = '{1'b1, 32'd5, 32'd3, 4'b0001, 1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2, 3'b000, 1'b0, '0, '0};
    vt[1]  = '{1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0};
    vt[2]  = '{1'b1, 32'd10, 32'd1, 4'b0000, 1'b1, 1'b1, 32'd20, 32'd2, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 32'd22, 3'b000};
    vt[3]  = '{1'b1, 32'd10, 32'd1, 4'b0000, 1'b1, 1'b1, 32'd20, 32'd2, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 32'd11, 3'b000, 1'b0, '0, '0};
    vt[4]  = '{1'b1, 32'd10, 32'd1, 4'b0000, 1'b1, 1'b1, 32'd20, 32'd2, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 32'd22, 3'b000};
    vt[5]  = '{1'b1, 32'd10, 32'd1, 4'b0000, 1'b1, 1'b1, 32'd20, 32'd2, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 32'd11, 3'b000, 1'b0, '0, '0};
    vt[6]  = '{1'b1, 32'd1, 32'd1, 4'b0000, 1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2, 3'b100, 1'b0, '0, '0};
    vt[7]  = '{1'b1, 32'd2, 32'd2, 4'b0000, 1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd4, 3'b100, 1'b0, '0, '0};
    vt[8]  = '{1'b1, 32'd3, 32'd3, 4'b0000, 1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd6, 3'b100, 1'b0, '0, '0};
    vt[9]  = '{1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0};
    vt[10] = '{1'b0, '0, '0, '0, 1'b1, 1'b1, 32'd3, 32'd5, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 32'hFFFF_FFFE, 3'b011};
    vt[11] = '{1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0};
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    #1;
    chk("rst_resp0_valid", bus.resp0_valid, 0);
    chk("rst_resp1_valid", bus.resp1_valid, 0);
    chk("rst_resp0_result", bus.resp0_result, 0);
    chk("rst_resp1_flags", bus.resp1_flags, 0);
    chk("rst_busy", bus.busy, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].v0, vt[i].a0, vt[i].b0, vt[i].c0, vt[i].rr0, vt[i].v1, vt[i].a1, vt[i].b1, vt[i].c1, vt[i].rr1);
      #1;
      chk($sformatf("v%0d_req0_ready", i), bus.req0_ready, vt[i].g0);
      chk($sformatf("v%0d_req1_ready", i), bus.req1_ready, vt[i].g1);
      if (!vt[i].g0 && !vt[i].g1) begin
        chk($sformatf("v%0d_idle_src_a", i), bus.alu_src_a, 0);
        chk($sformatf("v%0d_idle_src_b", i), bus.alu_src_b, 0);
        chk($sformatf("v%0d_idle_ctrl", i), bus.alu_ctrl, 0);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_resp0_valid", i), bus.resp0_valid, vt[i].rv0);
      chk($sformatf("v%0d_resp1_valid", i), bus.resp1_valid, vt[i].rv1);
      chk($sformatf("v%0d_busy", i), bus.busy, vt[i].rv0 | vt[i].rv1);
      if (vt[i].rv0) begin
        chk($sformatf("v%0d_resp0_result", i), bus.resp0_result, vt[i].r0);
        chk($sformatf("v%0d_resp0_flags", i), bus.resp0_flags, vt[i].f0);
      end
      if (vt[i].rv1) begin
        chk($sformatf("v%0d_resp1_result", i), bus.resp1_result, vt[i].r1);
        chk($sformatf("v%0d_resp1_flags", i), bus.resp1_flags, vt[i].f1);
      end
    end
    // Backpressure: slot 1 filled with resp1_ready low must hold and refuse new work.
    drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b1001, 1'b0);
    #1 chk("bp_accept", bus.req1_ready, 1);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 32'd7, 32'd7, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_req1_ready", i), bus.req1_ready, 0);
      chk($sformatf("bp%0d_resp1_valid", i), bus.resp1_valid, 1);
      chk($sformatf("bp%0d_resp1_result", i), bus.resp1_result, 0);
      chk($sformatf("bp%0d_resp1_flags", i), bus.resp1_flags, 3'b001);
      @(posedge clk); #1;
    end
    bus.resp1_ready = 1'b1;
    #1 chk("bp_refill_ready", bus.req1_ready, 1);
    @(posedge clk); #1;
    chk("bp_refill_valid", bus.resp1_valid, 1);
    chk("bp_refill_result", bus.resp1_result, 32'd14);
    chk("bp_refill_flags", bus.resp1_flags, 3'b100);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0, '0, 1'b1);
    @(posedge clk); #1;
    chk("bp_drained", bus.resp1_valid, 0);
    // Async reset while slot 0 holds a response.
    drive(1'b1, 32'd5, 32'd3, 4'b0001, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("hold_resp0_valid", bus.resp0_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_resp0_valid", bus.resp0_valid, 0);
    chk("arst_resp0_result", bus.resp0_result, 0);
    chk("arst_busy", bus.busy, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    drive(1'b1, 32'd1, 32'd2, 4'b0000, 1'b1, 1'b1, 32'd3, 32'd4, 4'b0000, 1'b1);
    #1;
    chk("post_rst_tie_g0", bus.req0_ready, 1);
    chk("post_rst_tie_g1", bus.req1_ready, 0);
    @(posedge clk); #1;
    chk("post_rst_result0", bus.resp0_result, 32'd3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters, e.g. the integer execute path (requester 0) and an address/branch helper (requester 1).
- Each requester presents operands and a 4-bit ALU control code with a valid/ready handshake.
- The arbiter drives the ALU for the granted requester and registers the ALU result and compare flags into that requester's response slot.
- Each response slot holds its data until the requester accepts it with a valid/ready handshake.

Parameters:
- XLEN, 32: operand and result width.
- CTRL_W, 4: ALU control code width.
- FLAG_W, 3: compare flag width. Bit 2 = equal, bit 1 = unsigned less-than, bit 0 = signed less-than.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  XLEN  requester 0 source A.
- req0_b  in  XLEN  requester 0 source B.
- req0_ctrl  in  CTRL_W  requester 0 ALU op.
- resp0_valid  out  1  requester 0 response held.
- resp0_ready  in  1  requester 0 consumes its response.
- resp0_result  out  XLEN  registered ALU result for requester 0.
- resp0_flags  out  FLAG_W  registered compare flags for requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl, resp1_valid, resp1_ready, resp1_result, resp1_flags: same as requester 0, for requester 1.
- alu_src_a  out  XLEN  to ALU.
- alu_src_b  out  XLEN  to ALU.
- alu_ctrl  out  CTRL_W  to ALU.
- alu_result  in  XLEN  from ALU, combinational.
- alu_flags  in  FLAG_W  from ALU, combinational.
- busy  out  1  either response slot is occupied.

Behaviour:
- Clock and reset (as decided): one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values:
  - resp0_valid = resp1_valid = 0.
  - resp*_result = 0, resp*_flags = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - busy = 0.
- Per-requester slot state machine, states EMPTY and FULL:
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY when resp_valid && resp_ready and no new grant in that cycle.
  - FULL -> FULL when drained and re-granted in the same cycle.
- Eligibility: requester k is eligible when req_k_valid && (slot_k EMPTY || resp_k_ready). Drain and refill may occur in the same cycle.
- Grant is combinational:
  - At most one grant per cycle.
  - Only one requester eligible: it is granted.
  - Both eligible: grant the requester != last_grant (round-robin).
  - req_k_ready = grant_k. Ready may depend on valid; requesters must not depend on ready to raise valid.
- ALU drive:
  - On a grant: alu_src_a/b/ctrl = the granted requester's a/b/ctrl, in the same cycle.
  - With no grant: alu_src_a = 0, alu_src_b = 0, alu_ctrl = 0, never X.
- Capture:
  - At the granting edge, resp_k_result <= alu_result, resp_k_flags <= alu_flags, resp_k_valid <= 1, last_grant <= k.
  - Latency: request accepted in cycle N -> resp_k_valid high from cycle N+1.
- Hold: while resp_k_valid && !resp_k_ready, result and flags are stable and req_k_ready = 0.
- Undefined ALU codes: an ALU result of X is captured as-is; the arbiter does not filter ctrl.
- Throughput: one accepted operation per cycle in total; each requester sustains one per cycle when alone and always ready.
- busy = resp0_valid | resp1_valid.
- Reset mid-operation: the asserted edge clears all slots immediately, including held responses. Pending requests are dropped and must be re-presented.
- last_grant changes only on a grant, not on idle cycles.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are eligible. last_grant is not implemented; eligibility and hold rules are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single op: after reset, req0 {a=5, b=3, ctrl=0001}, resp0_ready=1 -> req0_ready=1 in that cycle; next cycle resp0_valid=1, resp0_result=2, resp0_flags=3'b000; busy=1 for one cycle.
- Tie round-robin: both valid every cycle, both resp_ready=1 -> grants alternate 0,1,0,1. With ALU_ARB_FIXED_PRIO_EN, req0 is granted every cycle and req1_ready stays 0.
- Backpressure: req1 {a=0xFFFFFFFF, b=1, ctrl=1001} with resp1_ready=0 -> resp1_valid=1, result=0, flags=3'b001, all held while req1_ready=0 for 5 cycles. Raise resp1_ready -> a new req1 is accepted in the same cycle.
- Back-to-back drain/refill: req0 streams add ops {1+1, 2+2, 3+3} with resp0_ready=1 -> results 2, 4, 6 on consecutive cycles, no bubbles.
- Idle ALU drive: no valid requests -> alu_src_a=0, alu_src_b=0, alu_ctrl=0, no X on any output.
- Async reset mid-hold: resp0 FULL, assert rst_n=0 between clock edges -> resp0_valid, resp0_result and busy go to 0 immediately. After release, the next tie grants req0.
